// File: rtl/uart_pkt_rx.sv
// uart_pkt_rx: 8N1 UART byte receiver feeding a framed-packet decoder.
// Frame layout: HDR_BYTE, PAYLOAD_LEN data bytes, optional XOR checksum, 0x0D, 0x0A.
// Good frames update payload with a frame_valid pulse.
// Bad or stalled frames raise frame_err with a cause in err_code.
module uart_pkt_rx #(
    parameter int          CLK_FREQ    = 50_000_000,
    parameter int          UART_BPS    = 115200,
    parameter int          PAYLOAD_LEN = 5,
    parameter logic [7:0]  HDR_BYTE    = 8'h55,
    parameter bit          CHK_EN      = 1'b1,
    parameter int          TO_BITS     = 20
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,   // active-high despite the name
    input  logic                       uart_rxd,
    output logic [7:0]                 byte_data,
    output logic                       byte_valid,
    output logic [PAYLOAD_LEN*8-1:0]   payload,
    output logic                       frame_valid,
    output logic                       frame_err,
    output logic [1:0]                 err_code
);

    localparam int BPS_CNT  = CLK_FREQ / UART_BPS;
    localparam int HALF_CNT = BPS_CNT / 2;
    localparam int TO_LIMIT = BPS_CNT * TO_BITS;
    localparam int CNT_W    = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);
    localparam int IDX_W    = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_LEN - 1);

    localparam logic [1:0] ERR_FRAMING = 2'd0;
    localparam logic [1:0] ERR_CHKSUM  = 2'd1;
    localparam logic [1:0] ERR_TAIL    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_CHK,
        ST_TAIL0,
        ST_TAIL1
    } state_t;

    // ------------------------------------------------------------------
    // Byte receiver
    // ------------------------------------------------------------------
    logic             rxd_s1_q, rxd_s2_q, rxd_s3_q;
    logic             rx_busy_q, rx_busy_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;    // 0 = start, 1..8 = data, 9 = stop
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_data_q, byte_data_d;
    logic             byte_valid_q, byte_valid_d;
    logic             ferr_evt_q, ferr_evt_d;  // stop bit sampled low

    // Bit timing and mid-bit sampling; the stop-bit sample ends the byte so the
    // second half of the stop bit can already see the next start edge.
    always_comb begin
        rx_busy_d    = rx_busy_q;
        clk_cnt_d    = clk_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = 1'b0;
        ferr_evt_d   = 1'b0;
        if (!rx_busy_q) begin
            if (rxd_s3_q && !rxd_s2_q) begin
                rx_busy_d = 1'b1;
                clk_cnt_d = '0;
                bit_cnt_d = '0;
            end
        end else begin
            if (clk_cnt_q == CNT_W'(BPS_CNT - 1)) begin
                clk_cnt_d = '0;
                bit_cnt_d = bit_cnt_q + 4'd1;
            end else begin
                clk_cnt_d = clk_cnt_q + 1'b1;
            end
            if (clk_cnt_q == CNT_W'(HALF_CNT)) begin
                if (bit_cnt_q == 4'd0) begin
                    // Line back high at mid start bit: glitch, not a start.
                    if (rxd_s2_q) begin
                        rx_busy_d = 1'b0;
                    end
                end else if (bit_cnt_q <= 4'd8) begin
                    shift_d = {rxd_s2_q, shift_q[7:1]};
                end else begin
                    rx_busy_d = 1'b0;
                    if (rxd_s2_q) begin
                        byte_data_d  = shift_q;
                        byte_valid_d = 1'b1;
                    end else begin
                        ferr_evt_d = 1'b1;
                    end
                end
            end
        end
    end

    // Receiver state and input synchroniser (synchroniser resets to idle-high).
    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            rxd_s1_q     <= 1'b1;
            rxd_s2_q     <= 1'b1;
            rxd_s3_q     <= 1'b1;
            rx_busy_q    <= 1'b0;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            ferr_evt_q   <= 1'b0;
        end else begin
            rxd_s1_q     <= uart_rxd;
            rxd_s2_q     <= rxd_s1_q;
            rxd_s3_q     <= rxd_s2_q;
            rx_busy_q    <= rx_busy_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            ferr_evt_q   <= ferr_evt_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame decoder
    // ------------------------------------------------------------------
    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [7:0]               acc_q, acc_d;
    logic [7:0]               shadow_q [PAYLOAD_LEN];
    logic [7:0]               shadow_d [PAYLOAD_LEN];
    logic [PAYLOAD_LEN*8-1:0] shadow_flat;
    logic [PAYLOAD_LEN*8-1:0] payload_q, payload_d;
    logic                     frame_valid_q, frame_valid_d;
    logic                     frame_err_q, frame_err_d;
    logic [1:0]               err_code_q, err_code_d;
    logic [TO_W-1:0]          to_cnt_q, to_cnt_d;

    // Byte 0 of the shadow buffer lands in the low bits of the payload word.
    for (genvar gi = 0; gi < PAYLOAD_LEN; gi++) begin : g_flat
        assign shadow_flat[gi*8 +: 8] = shadow_q[gi];
    end

    // Frame state machine; good bytes take priority, then stop-bit errors,
    // then the inter-byte timeout, so a byte arriving on the limit still counts.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        acc_d         = acc_q;
        shadow_d      = shadow_q;
        payload_d     = payload_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        err_code_d    = err_code_q;
        to_cnt_d      = to_cnt_q;
        if (byte_valid_q) begin
            to_cnt_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (byte_data_q == HDR_BYTE) begin
                        state_d = ST_PAYLOAD;
                        idx_d   = '0;
                        acc_d   = '0;
                    end
                end
                ST_PAYLOAD: begin
                    for (int i = 0; i < PAYLOAD_LEN; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            shadow_d[i] = byte_data_q;
                        end
                    end
                    acc_d = acc_q ^ byte_data_q;
                    if (idx_q == IDX_LAST) begin
                        state_d = CHK_EN ? ST_CHK : ST_TAIL0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                ST_CHK: begin
                    if (byte_data_q != acc_q) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CHKSUM;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_TAIL0;
                    end
                end
                ST_TAIL0: begin
                    if (byte_data_q == 8'h0D) begin
                        state_d = ST_TAIL1;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_TAIL;
                        state_d     = ST_IDLE;
                    end
                end
                ST_TAIL1: begin
                    if (byte_data_q == 8'h0A) begin
                        payload_d     = shadow_flat;
                        frame_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_TAIL;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (ferr_evt_q) begin
            to_cnt_d = '0;
            if (state_q != ST_IDLE) begin
                frame_err_d = 1'b1;
                err_code_d  = ERR_FRAMING;
                state_d     = ST_IDLE;
            end
        end else if (state_q != ST_IDLE) begin
            if (to_cnt_q == TO_W'(TO_LIMIT - 1)) begin
                to_cnt_d    = '0;
                frame_err_d = 1'b1;
                err_code_d  = ERR_TIMEOUT;
                state_d     = ST_IDLE;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end else begin
            to_cnt_d = '0;
        end
    end

    // Frame decoder registers, including the registered output pulses.
    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            acc_q         <= '0;
            for (int i = 0; i < PAYLOAD_LEN; i++) begin
                shadow_q[i] <= '0;
            end
            payload_q     <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_code_q    <= '0;
            to_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            acc_q         <= acc_d;
            shadow_q      <= shadow_d;
            payload_q     <= payload_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            err_code_q    <= err_code_d;
            to_cnt_q      <= to_cnt_d;
        end
    end

    assign byte_data   = byte_data_q;
    assign byte_valid  = byte_valid_q;
    assign payload     = payload_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign err_code    = err_code_q;

endmodule
